// File: rtl/sys_rst_seq.sv
// sys_rst_seq: board-reset synchronizer and staged active-low reset release sequencer
//
//   sysclk_200mhz  in   system clock
//   sys_rst_n      in   board reset, asynchronous assert, active-low
//   soft_rst_req   in   synchronous soft-reset request (level); re-runs the whole sequence
//   rst_out_n      out  sequenced active-low resets, bit 0 released first
//   rst_done       out  high once every rst_out_n bit is released
//   rst_state      out  FSM state: 0=ASSERT 1=HOLD 2=RELEASE 3=RUN
//   heartbeat      out  toggles every HB_DIV cycles in RUN when SYS_RST_HEARTBEAT_EN is defined,
//                       otherwise tied to 0
module sys_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_GAP   = 16,
    parameter int HB_DIV      = 2**24
) (
    input  logic                  sysclk_200mhz,
    input  logic                  sys_rst_n,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  rst_done,
    output logic [1:0]            rst_state,
    output logic                  heartbeat
);
    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || NUM_STAGES < 1 || NUM_STAGES > 16 ||
        STAGE_GAP < 1 || HB_DIV < 1) begin : g_bad_params
        $error("sys_rst_seq: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_ok;
    logic [HW-1:0]          hold_cnt;
    logic [GW-1:0]          gap_cnt;
    logic [NUM_STAGES-1:0]  out_next;

    assign sync_ok = sync_chain[SYNC_STAGES-1];
    // Released bits form a thermometer code, so the next release shifts in another 1.
    assign out_next = (rst_out_n << 1) | NUM_STAGES'(1);

    always_ff @(posedge sysclk_200mhz or negedge sys_rst_n) begin
        if (!sys_rst_n)
            sync_chain <= '0;
        else
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], 1'b1};
    end

    // ASSERT is only entered through reset or a soft request, both of which clear
    // the counters, so HOLD always starts counting from zero.
    always_ff @(posedge sysclk_200mhz or negedge sys_rst_n) begin
        if (!sys_rst_n || soft_rst_req) begin
            rst_state <= ST_ASSERT;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            rst_out_n <= '0;
            rst_done  <= 1'b0;
        end else begin
            case (rst_state)
                ST_ASSERT: if (sync_ok) rst_state <= ST_HOLD;
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        rst_out_n <= out_next;
                        gap_cnt   <= '0;
                        rst_done  <= (NUM_STAGES == 1);
                        rst_state <= (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        rst_out_n <= out_next;
                        gap_cnt   <= '0;
                        if (out_next[NUM_STAGES-1]) begin
                            rst_done  <= 1'b1;
                            rst_state <= ST_RUN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SYS_RST_HEARTBEAT_EN
    localparam int DW = $clog2(HB_DIV) + 1;
    localparam logic [DW-1:0] HB_LAST = DW'(HB_DIV - 1);

    logic [DW-1:0] hb_cnt;

    // A soft request on a RUN edge clears the heartbeat on that same edge.
    always_ff @(posedge sysclk_200mhz or negedge sys_rst_n) begin
        if (!sys_rst_n || soft_rst_req || rst_state != ST_RUN) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end
`else
    assign heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_sys_rst_seq.sv
// tb_sys_rst_seq: scoreboard bench for sys_rst_seq against an elapsed-time reference model
module tb_sys_rst_seq;
    localparam int SYNC  = 2;
    localparam int HOLD  = 8;
    localparam int NS    = 3;
    localparam int GAP   = 4;
    localparam int HBD   = 5;
    localparam int T_RUN = HOLD + (NS - 1) * GAP;

    typedef struct packed {
        logic [NS-1:0] out;
        logic          done;
        logic [1:0]    st;
        logic          hb;
    } exp_t;

    logic          clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic [NS-1:0] rst_out_n;
    logic          rst_done;
    logic [1:0]    rst_state;
    logic          heartbeat;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   sync_cnt = 0;
    int   t = -1;
    exp_t q[$];
    exp_t mon_e;

    sys_rst_seq #(
        .SYNC_STAGES(SYNC),
        .HOLD_CYCLES(HOLD),
        .NUM_STAGES(NS),
        .STAGE_GAP(GAP),
        .HB_DIV(HBD)
    ) dut (
        .sysclk_200mhz(clk),
        .sys_rst_n(sys_rst_n),
        .soft_rst_req(soft_rst_req),
        .rst_out_n(rst_out_n),
        .rst_done(rst_done),
        .rst_state(rst_state),
        .heartbeat(heartbeat)
    );

    always #5 clk = ~clk;

    // Everything is a function of t, the number of edges since the sequence entered HOLD
    // (-1 while in ASSERT).
    function automatic exp_t expect_of(int tt);
        exp_t e;
        e = '0;
        for (int i = 0; i < NS; i++) e.out[i] = (tt >= HOLD + i * GAP);
        e.done = (tt >= T_RUN);
        e.st = (tt < 0) ? 2'd0 : (tt < HOLD) ? 2'd1 : (tt < T_RUN) ? 2'd2 : 2'd3;
`ifdef SYS_RST_HEARTBEAT_EN
        e.hb = (tt >= T_RUN) && (((tt - T_RUN) / HBD) % 2 == 1);
`endif
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!sys_rst_n) begin
            sync_cnt = 0;
            t = -1;
        end else begin
            if (soft_rst_req) t = -1;
            else if (t < 0) t = (sync_cnt >= SYNC) ? 0 : -1;
            else if (t < 1000000) t++;
            if (sync_cnt < SYNC) sync_cnt++;
        end
        q.push_back(expect_of(t));
    end

    // An asynchronous assert overrides whatever this cycle's edge produced.
    always @(negedge sys_rst_n) begin
        sync_cnt = 0;
        t = -1;
        if (q.size() > 0) q[q.size()-1] = expect_of(-1);
    end

    task automatic check(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("rst_out_n", int'(rst_out_n), int'(mon_e.out));
            check("rst_done", int'(rst_done), int'(mon_e.done));
            check("rst_state", int'(rst_state), int'(mon_e.st));
            check("heartbeat", int'(heartbeat), int'(mon_e.hb));
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic soft_pulse();
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
    endtask

    initial begin
        int guard;
        int r;
        tick(5);
        sys_rst_n = 1'b1;
        tick(30);
        sys_rst_n = 1'b0;
        #2;
        sys_rst_n = 1'b1;
        tick(30);
        soft_pulse();
        tick(30);
        soft_pulse();
        guard = 0;
        while (t != HOLD + GAP - 1 && guard < 50) begin
            tick(1);
            guard++;
        end
        tests++;
        if (guard >= 50) begin
            fails++;
            $display("FAIL wait_bit1 cyc=%0d got=%0d want=%0d", cyc, t, HOLD + GAP - 1);
        end
        soft_pulse();
        tick(10);
        soft_rst_req = 1'b1;
        tick(20);
        soft_rst_req = 1'b0;
        tick(30);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 199);
            if (r < 3) begin
                sys_rst_n = 1'b0;
                #1;
                sys_rst_n = 1'b1;
                tick(1);
            end else if (r < 5) begin
                sys_rst_n = 1'b0;
                tick($urandom_range(1, 3));
                sys_rst_n = 1'b1;
            end else if (r < 9) begin
                soft_rst_req = 1'b1;
                tick($urandom_range(1, 4));
                soft_rst_req = 1'b0;
            end else begin
                tick(1);
            end
        end
        tick(30);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
